dom_gf2_share_masker: RTL and testbench

// - Transmit side of the shared GF(2^2) multiplier interface. Takes unmasked 2-bit operands X, Y
//   and one fresh random word per operation. Emits SHARES-way Boolean sharings of X and Y plus the
//   Z (remask) and B (blind) randomness the DOM multiplier consumes.
// - Sits between the operand/RNG sources and real_dom_shared_sqscmul_gf2.
// - Output bundle is registered behind a valid/ready handshake.
// - Every random word is used exactly once.

---
 rtl/dom_gf2_share_masker_if.sv | 34 +++
 rtl/dom_gf2_share_masker.sv | 103 ++++++++++
 tb/tb_dom_gf2_share_masker.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dom_gf2_share_masker_if.sv
// Operand, randomness and share-bundle signals between the masker and its neighbours.
// The slave modport is the masker; the master modport is the operand/RNG source plus the downstream sink.
interface dom_gf2_share_masker_if #(
   parameter int SHARES                   = 2,
   parameter int FIRST_ORDER_OPTIMIZATION = 1
);
   localparam int BLIND_NRND = (FIRST_ORDER_OPTIMIZATION != 0 && SHARES == 2) ? 1 : SHARES;
   localparam int RND_W      = 4*(SHARES-1) + SHARES*(SHARES-1) + 2*BLIND_NRND;

   logic [1:0]                   XxDI;
   logic [1:0]                   YxDI;
   logic                         InValidxSI;
   logic                         InReadyxSO;
   logic [RND_W-1:0]             RndxDI;
   logic                         RndValidxSI;
   logic                         RndReadyxSO;
   logic [2*SHARES-1:0]          _XxDO;
   logic [2*SHARES-1:0]          _YxDO;
   logic [SHARES*(SHARES-1)-1:0] _ZxDO;
   logic [2*BLIND_NRND-1:0]      _BxDO;
   logic                         OutValidxSO;
   logic                         OutReadyxSI;
   logic [15:0]                  RndCntxDO;

   modport slave (
      input  XxDI, YxDI, InValidxSI, RndxDI, RndValidxSI, OutReadyxSI,
      output InReadyxSO, RndReadyxSO, _XxDO, _YxDO, _ZxDO, _BxDO, OutValidxSO, RndCntxDO
   );

   modport master (
      output XxDI, YxDI, InValidxSI, RndxDI, RndValidxSI, OutReadyxSI,
      input  InReadyxSO, RndReadyxSO, _XxDO, _YxDO, _ZxDO, _BxDO, OutValidxSO, RndCntxDO
   );
endinterface

// File: rtl/dom_gf2_share_masker.sv
// Splits unmasked GF(2^2) operands into Boolean shares using one fresh random word per operation
// and presents shares plus Z/B randomness as a registered one-deep valid/ready bundle.
module dom_gf2_share_masker #(
   parameter int SHARES                   = 2,
   parameter int FIRST_ORDER_OPTIMIZATION = 1
) (
   input  logic                    ClkxCI,
   input  logic                    RstxBI,
   dom_gf2_share_masker_if.slave   bus
);
   localparam int BLIND_NRND = (FIRST_ORDER_OPTIMIZATION != 0 && SHARES == 2) ? 1 : SHARES;
   localparam int MASK_W     = 2*(SHARES-1);
   localparam int Z_W        = SHARES*(SHARES-1);
   localparam int B_W        = 2*BLIND_NRND;
   localparam int RND_W      = 2*MASK_W + Z_W + B_W;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]          state_q, state_d;
   logic [2*SHARES-1:0] x_q, y_q;
   logic [Z_W-1:0]      z_q;
   logic [B_W-1:0]      b_q;
   logic [15:0]         cnt_q, cnt_d;

   logic [MASK_W-1:0]   x_mask, y_mask;
   logic [Z_W-1:0]      z_rnd;
   logic [B_W-1:0]      b_rnd;
   logic [1:0]          x_share0, y_share0;
   logic [2*SHARES-1:0] x_sh, y_sh;
   logic                slot_free, fire;

   assign x_mask = bus.RndxDI[MASK_W-1:0];
   assign y_mask = bus.RndxDI[2*MASK_W-1:MASK_W];
   assign z_rnd  = bus.RndxDI[2*MASK_W+Z_W-1:2*MASK_W];
   assign b_rnd  = bus.RndxDI[RND_W-1:2*MASK_W+Z_W];

   // Share 0 absorbs every mask so that the XOR of all shares recovers the operand.
   always_comb begin
      x_share0 = bus.XxDI;
      y_share0 = bus.YxDI;
      for (int j = 0; j < SHARES-1; j++) begin
         x_share0 = x_share0 ^ x_mask[2*j +: 2];
         y_share0 = y_share0 ^ y_mask[2*j +: 2];
      end
   end

   assign x_sh[1:0] = x_share0;
   assign y_sh[1:0] = y_share0;

   genvar gi;
   generate
      for (gi = 1; gi < SHARES; gi++) begin : g_share
         assign x_sh[2*gi+1:2*gi] = x_mask[2*gi-1:2*gi-2];
         assign y_sh[2*gi+1:2*gi] = y_mask[2*gi-1:2*gi-2];
      end
   endgenerate

   // Operands and randomness are only ever taken together, so a mask is never reused or paired late.
   assign slot_free = (state_q == ST_EMPTY) || bus.OutReadyxSI;
   assign fire      = RstxBI && bus.InValidxSI && bus.RndValidxSI && slot_free;

   assign bus.InReadyxSO  = fire;
   assign bus.RndReadyxSO = fire;

   always_comb begin
      state_d = state_q;
      if (fire) begin
         state_d = ST_FULL;
      end else if (state_q == ST_FULL && bus.OutReadyxSI) begin
         state_d = ST_EMPTY;
      end
   end

   assign cnt_d = (fire && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

   always_ff @(posedge ClkxCI) begin
      if (!RstxBI) begin
         state_q <= ST_EMPTY;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (fire) begin
            x_q <= x_sh;
            y_q <= y_sh;
            z_q <= z_rnd;
            b_q <= b_rnd;
         end
      end
   end

   assign bus._XxDO       = x_q;
   assign bus._YxDO       = y_q;
   assign bus._ZxDO       = z_q;
   assign bus._BxDO       = b_q;
   assign bus.OutValidxSO = (state_q == ST_FULL);
   assign bus.RndCntxDO   = cnt_q;
endmodule

// File: tb/tb_dom_gf2_share_masker.sv
// Self-checking bench for dom_gf2_share_masker: directed scenarios plus a randomized stream
// checked against a transaction-level queue model.
module tb_dom_gf2_share_masker;
   localparam int SHARES     = 2;
   localparam int FOO        = 1;
   localparam int BLIND_NRND = (FOO != 0 && SHARES == 2) ? 1 : SHARES;
   localparam int MASK_W     = 2*(SHARES-1);
   localparam int Z_W        = SHARES*(SHARES-1);
   localparam int B_W        = 2*BLIND_NRND;
   localparam int RND_W      = 2*MASK_W + Z_W + B_W;
   localparam int N_STREAM   = 1000;

   typedef struct {
      logic [1:0]       x;
      logic [1:0]       y;
      logic [RND_W-1:0] rnd;
   } op_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   dom_gf2_share_masker_if #(.SHARES(SHARES), .FIRST_ORDER_OPTIMIZATION(FOO)) bus ();

   dom_gf2_share_masker #(.SHARES(SHARES), .FIRST_ORDER_OPTIMIZATION(FOO)) dut (
      .ClkxCI (clk),
      .RstxBI (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int          vectors     = 0;
   int          miscompares = 0;
   logic        m_full      = 1'b0;
   logic [15:0] m_cnt       = '0;
   op_t         m_q[$];

   function automatic logic [1:0] xor_shares(input logic [2*SHARES-1:0] s);
      logic [1:0] r = '0;
      for (int j = 0; j < SHARES; j++) r = r ^ s[2*j +: 2];
      return r;
   endfunction

   // Rebuild the random word from the non-derived shares and Z/B, following the LSB-first slicing.
   function automatic logic [RND_W-1:0] rnd_from_out(input logic [2*SHARES-1:0] xo,
                                                     input logic [2*SHARES-1:0] yo,
                                                     input logic [Z_W-1:0] zo,
                                                     input logic [B_W-1:0] bo);
      logic [RND_W-1:0] r = '0;
      for (int j = 1; j < SHARES; j++) begin
         r[2*(j-1) +: 2]        = xo[2*j +: 2];
         r[MASK_W+2*(j-1) +: 2] = yo[2*j +: 2];
      end
      r[2*MASK_W +: Z_W]     = zo;
      r[2*MASK_W+Z_W +: B_W] = bo;
      return r;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.x   = 2'($urandom_range(0, 3));
      o.y   = 2'($urandom_range(0, 3));
      o.rnd = RND_W'($urandom);
      return o;
   endfunction

   task automatic drive(input op_t o, input logic inv, input logic rndv, input logic ordy);
      bus.XxDI        = o.x;
      bus.YxDI        = o.y;
      bus.RndxDI      = o.rnd;
      bus.InValidxSI  = inv;
      bus.RndValidxSI = rndv;
      bus.OutReadyxSI = ordy;
   endtask

   // Advance one clock and update the transaction model from what was offered before the edge.
   task automatic tick();
      logic f;
      op_t  o;
      f     = rstn && bus.InValidxSI && bus.RndValidxSI && (!m_full || bus.OutReadyxSI);
      o.x   = bus.XxDI;
      o.y   = bus.YxDI;
      o.rnd = bus.RndxDI;
      @(posedge clk);
      if (!rstn) begin
         m_full = 1'b0;
         m_cnt  = '0;
         m_q.delete();
      end else if (f) begin
         m_full = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         m_q.push_back(o);
      end else if (m_full && bus.OutReadyxSI) begin
         m_full = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      op_t o;
      o = rand_op();
      rstn = 1'b0;
      drive(o, 1'b1, 1'b1, 1'b1);
      #1;
      vectors++;
      if (bus.InReadyxSO !== 1'b0 || bus.RndReadyxSO !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready: got in=%b rnd=%b want 0/0", bus.InReadyxSO, bus.RndReadyxSO);
      end
      tick();
      tick();
      vectors++;
      if (bus.OutValidxSO !== 1'b0 || bus.InReadyxSO !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got outvalid=%b inready=%b want 0/0", bus.OutValidxSO, bus.InReadyxSO);
      end
      vectors++;
      if (bus._XxDO !== '0 || bus._YxDO !== '0 || bus._ZxDO !== '0 || bus._BxDO !== '0 || bus.RndCntxDO !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_data: got X=%h Y=%h Z=%h B=%h cnt=%0d want all 0",
                  bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO, bus.RndCntxDO);
      end
      $display("test_reset: done");
   endtask

   task automatic test_single();
      op_t o;
      o.x = 2'b10;
      o.y = 2'b01;
      o.rnd = 8'hB4;
      rstn = 1'b1;
      drive(o, 1'b1, 1'b1, 1'b1);
      #1;
      vectors++;
      if (bus.InReadyxSO !== 1'b1 || bus.RndReadyxSO !== 1'b1) begin
         miscompares++;
         $display("FAIL single_ready: got in=%b rnd=%b want 1/1", bus.InReadyxSO, bus.RndReadyxSO);
      end
      tick();
      drive(o, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (bus.OutValidxSO !== 1'b1 || bus._XxDO !== 4'b0010 || bus._YxDO !== 4'b0100 ||
          bus._ZxDO !== 2'b11 || bus._BxDO !== 2'b10 || bus.RndCntxDO !== 16'd1) begin
         miscompares++;
         $display("FAIL single_op: got v=%b X=%b Y=%b Z=%b B=%b cnt=%0d want 1 0010 0100 11 10 1",
                  bus.OutValidxSO, bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO, bus.RndCntxDO);
      end
      $display("test_single: X=%b Y=%b rnd=%h", o.x, o.y, o.rnd);
   endtask

   task automatic test_backpressure();
      op_t o;
      logic [2*SHARES-1:0] sx, sy;
      logic [Z_W-1:0] sz;
      logic [B_W-1:0] sb;
      logic [15:0] scnt;
      o = rand_op();
      drive(o, 1'b1, 1'b1, 1'b1);
      tick();
      sx = bus._XxDO; sy = bus._YxDO; sz = bus._ZxDO; sb = bus._BxDO; scnt = bus.RndCntxDO;
      vectors++;
      if (xor_shares(sx) !== o.x || xor_shares(sy) !== o.y || rnd_from_out(sx, sy, sz, sb) !== o.rnd) begin
         miscompares++;
         $display("FAIL bp_load: got x=%b y=%b rnd=%h want x=%b y=%b rnd=%h", xor_shares(sx),
                  xor_shares(sy), rnd_from_out(sx, sy, sz, sb), o.x, o.y, o.rnd);
      end
      for (int i = 0; i < 5; i++) begin
         o = rand_op();
         drive(o, 1'b1, 1'b1, 1'b0);
         #1;
         vectors++;
         if (bus.InReadyxSO !== 1'b0 || bus.RndReadyxSO !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready[%0d]: got in=%b rnd=%b want 0/0", i, bus.InReadyxSO, bus.RndReadyxSO);
         end
         tick();
         vectors++;
         if (bus.OutValidxSO !== 1'b1 || bus._XxDO !== sx || bus._YxDO !== sy || bus._ZxDO !== sz ||
             bus._BxDO !== sb || bus.RndCntxDO !== scnt) begin
            miscompares++;
            $display("FAIL bp_hold[%0d]: got v=%b X=%h Y=%h Z=%h B=%h cnt=%0d want 1 %h %h %h %h %0d", i,
                     bus.OutValidxSO, bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO, bus.RndCntxDO,
                     sx, sy, sz, sb, scnt);
         end
      end
      for (int i = 0; i < 4; i++) begin
         o = rand_op();
         drive(o, 1'b1, 1'b1, 1'b1);
         #1;
         vectors++;
         if (bus.InReadyxSO !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_ready[%0d]: got %b want 1", i, bus.InReadyxSO);
         end
         tick();
         vectors++;
         if (bus.OutValidxSO !== 1'b1 || xor_shares(bus._XxDO) !== o.x || xor_shares(bus._YxDO) !== o.y ||
             rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO) !== o.rnd ||
             bus.RndCntxDO !== scnt + 16'(i + 1)) begin
            miscompares++;
            $display("FAIL b2b_data[%0d]: got v=%b x=%b y=%b rnd=%h cnt=%0d want 1 %b %b %h %0d", i,
                     bus.OutValidxSO, xor_shares(bus._XxDO), xor_shares(bus._YxDO),
                     rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO), bus.RndCntxDO,
                     o.x, o.y, o.rnd, scnt + 16'(i + 1));
         end
      end
      $display("test_backpressure: done");
   endtask

   task automatic test_starve();
      op_t o;
      logic [15:0] scnt;
      scnt = bus.RndCntxDO;
      for (int i = 0; i < 3; i++) begin
         o = rand_op();
         drive(o, 1'b1, 1'b0, 1'b1);
         #1;
         vectors++;
         if (bus.InReadyxSO !== 1'b0 || bus.RndReadyxSO !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_ready[%0d]: got in=%b rnd=%b want 0/0", i, bus.InReadyxSO, bus.RndReadyxSO);
         end
         tick();
         vectors++;
         if (bus.OutValidxSO !== 1'b0 || bus.RndCntxDO !== scnt) begin
            miscompares++;
            $display("FAIL starve_state[%0d]: got v=%b cnt=%0d want 0 %0d", i, bus.OutValidxSO,
                     bus.RndCntxDO, scnt);
         end
      end
      $display("test_starve: done");
   endtask

   task automatic test_stream();
      op_t o, e;
      logic inv, rndv, ordy, exp_rdy;
      int sent = 0, got = 0, cyc = 0;
      rstn = 1'b0;
      drive(rand_op(), 1'b0, 1'b0, 1'b0);
      tick();
      rstn = 1'b1;
      while (got < N_STREAM && cyc < 20000) begin
         cyc++;
         o    = rand_op();
         inv  = (sent < N_STREAM) && ($urandom_range(0, 4) != 0);
         rndv = ($urandom_range(0, 4) != 0);
         ordy = ($urandom_range(0, 9) < 7);
         drive(o, inv, rndv, ordy);
         #1;
         exp_rdy = inv && rndv && (!m_full || ordy);
         vectors++;
         if (bus.InReadyxSO !== exp_rdy || bus.RndReadyxSO !== exp_rdy || bus.OutValidxSO !== m_full) begin
            miscompares++;
            $display("FAIL stream_hs cyc %0d: got in=%b rnd=%b v=%b want %b %b %b", cyc,
                     bus.InReadyxSO, bus.RndReadyxSO, bus.OutValidxSO, exp_rdy, exp_rdy, m_full);
         end
         if (bus.OutValidxSO === 1'b1 && ordy) begin
            vectors++;
            if (m_q.size() == 0) begin
               miscompares++;
               $display("FAIL stream_extra cyc %0d: got bundle want none pending", cyc);
            end else begin
               e = m_q.pop_front();
               if (xor_shares(bus._XxDO) !== e.x || xor_shares(bus._YxDO) !== e.y ||
                   rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO) !== e.rnd) begin
                  miscompares++;
                  $display("FAIL stream_data #%0d: got x=%b y=%b rnd=%h want x=%b y=%b rnd=%h", got,
                           xor_shares(bus._XxDO), xor_shares(bus._YxDO),
                           rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO), e.x, e.y, e.rnd);
               end
            end
            got++;
         end
         if (exp_rdy) sent++;
         tick();
      end
      vectors++;
      if (got < N_STREAM) begin
         miscompares++;
         $display("FAIL stream_timeout: got %0d bundles want %0d", got, N_STREAM);
      end
      drive(rand_op(), 1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.RndCntxDO !== 16'(N_STREAM)) begin
         miscompares++;
         $display("FAIL stream_cnt: got %0d want %0d", bus.RndCntxDO, N_STREAM);
      end
      $display("test_stream: %0d ops in %0d cycles", got, cyc);
   endtask

   task automatic test_mid_reset();
      op_t o;
      o = rand_op();
      drive(o, 1'b1, 1'b1, 1'b1);
      tick();
      drive(rand_op(), 1'b0, 1'b0, 1'b0);
      tick();
      rstn = 1'b0;
      drive(rand_op(), 1'b1, 1'b1, 1'b0);
      #1;
      vectors++;
      if (bus.InReadyxSO !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_ready: got %b want 0", bus.InReadyxSO);
      end
      tick();
      vectors++;
      if (bus.OutValidxSO !== 1'b0 || bus._XxDO !== '0 || bus._YxDO !== '0 || bus._ZxDO !== '0 ||
          bus._BxDO !== '0 || bus.RndCntxDO !== 16'd0) begin
         miscompares++;
         $display("FAIL midrst_state: got v=%b X=%h Y=%h Z=%h B=%h cnt=%0d want all 0", bus.OutValidxSO,
                  bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO, bus.RndCntxDO);
      end
      rstn = 1'b1;
      o = rand_op();
      drive(o, 1'b1, 1'b1, 1'b1);
      tick();
      vectors++;
      if (bus.OutValidxSO !== 1'b1 || xor_shares(bus._XxDO) !== o.x || xor_shares(bus._YxDO) !== o.y ||
          rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO) !== o.rnd || bus.RndCntxDO !== 16'd1) begin
         miscompares++;
         $display("FAIL midrst_first: got v=%b x=%b y=%b rnd=%h cnt=%0d want 1 %b %b %h 1", bus.OutValidxSO,
                  xor_shares(bus._XxDO), xor_shares(bus._YxDO),
                  rnd_from_out(bus._XxDO, bus._YxDO, bus._ZxDO, bus._BxDO), bus.RndCntxDO, o.x, o.y, o.rnd);
      end
      $display("test_mid_reset: done");
   endtask

   initial begin
      drive(rand_op(), 1'b0, 1'b0, 1'b0);
      test_reset();
      test_single();
      test_backpressure();
      test_starve();
      test_stream();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end
endmodule
